// File: rtl/bg_image_writer_if.sv
// bg_image_writer_if: byte stream in, RGB565 RAM write port out
interface bg_image_writer_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  modport master (output in_byte, in_valid, input in_ready, mem_addr, mem_wdata, mem_we);
  modport slave  (input in_byte, in_valid, output in_ready, mem_addr, mem_wdata, mem_we);
endinterface

// File: rtl/bg_image_writer.sv
// bg_image_writer: packs byte pairs into RGB565 words and writes one image to RAM outside bright
module bg_image_writer #(
  parameter int          BG_WIDTH  = 180,
  parameter int          BG_HEIGHT = 180,
  parameter logic [16:0] BASE_ADDR = 17'd5120
) (
  input  logic               pix_clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               bright,
  bg_image_writer_if.slave   bus,
  output logic               busy,
  output logic               done,
  output logic [15:0]        pixel_count
);
  localparam logic [15:0] LAST = 16'(BG_WIDTH * BG_HEIGHT - 1);
  typedef enum logic [2:0] {IDLE, HI, LO, WR, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, wdata_q, wdata_d;
  logic [16:0] addr_q, addr_d;
  always_ff @(posedge pix_clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      wdata_q <= '0;
      addr_q  <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
    end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: if (start) begin state_d = HI; pc_d = '0; end
      HI:   if (bus.in_valid) begin state_d = LO; wdata_d[15:8] = bus.in_byte; end
      LO:   if (bus.in_valid) begin state_d = WR; wdata_d[7:0] = bus.in_byte; end
      WR:   if (!bright) begin pc_d = pc_q + 16'd1; state_d = pc_q == LAST ? DONE : HI; end
      default: state_d = IDLE;
    endcase
    // address tracks the count it will be used with, so it is ready in the WR cycle
    addr_d = BASE_ADDR + {1'b0, pc_d};
  end
  assign bus.in_ready  = state_q == HI || state_q == LO;
  assign bus.mem_we    = state_q == WR && !bright;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = state_q == HI || state_q == LO || state_q == WR;
  assign done          = state_q == DONE;
  assign pixel_count   = pc_q;
endmodule

// File: tb/tb_bg_image_writer.sv
// tb_bg_image_writer: random-gap stream into a 4x2 image, checked every cycle against a pixel-level model
module tb_bg_image_writer;
  localparam int          W = 4, H = 2, PIXELS = W * H;
  localparam logic [16:0] BASE = 17'd5120;
  logic pix_clk = 0, rst_n = 1, start = 0, bright = 0, rnd_bright = 0;
  logic busy, done;
  logic [15:0] pixel_count;
  bg_image_writer_if bus();
  bg_image_writer #(.BG_WIDTH(W), .BG_HEIGHT(H), .BASE_ADDR(BASE)) dut (
    .pix_clk(pix_clk), .rst_n(rst_n), .start(start), .bright(bright), .bus(bus),
    .busy(busy), .done(done), .pixel_count(pixel_count));
  always #5 pix_clk = ~pix_clk;
  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // model: a load is a list of accepted bytes; pixel k is {byte 2k, byte 2k+1} at BASE+k
  logic [7:0] bytes[$];
  logic m_active = 0, m_done = 0;
  int m_bytes = 0, m_pc = 0, m_writes = 0, m_loads = 0, dut_dones = 0;
  always @(negedge pix_clk) begin
    logic pend, acc, wr;
    if (!rst_n) begin
      check("rst_we", bus.mem_we, 0);
      check("rst_ready", bus.in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pc", pixel_count, 0);
      check("rst_addr", bus.mem_addr, BASE);
      check("rst_wdata", bus.mem_wdata, 0);
      m_active = 0; m_done = 0; m_bytes = 0; m_pc = 0; bytes.delete();
    end else begin
      pend = m_active && m_bytes == 2 * m_pc + 2;
      acc  = bus.in_valid && m_active && !pend;
      wr   = pend && !bright;
      check("ready", bus.in_ready, m_active && !pend);
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("pc", pixel_count, m_pc);
      check("we", bus.mem_we, wr);
      if (bus.mem_we && pend) begin
        check("addr", bus.mem_addr, BASE + 17'(m_pc));
        check("wdata", bus.mem_wdata, {bytes[2 * m_pc], bytes[2 * m_pc + 1]});
      end
      if (done) dut_dones++;
      if (m_done) m_done = 0;
      else if (!m_active && start) begin
        m_active = 1; m_bytes = 0; m_pc = 0; bytes.delete();
      end
      if (acc) begin bytes.push_back(bus.in_byte); m_bytes++; end
      if (wr) begin
        m_pc++; m_writes++;
        if (m_pc == PIXELS) begin m_active = 0; m_done = 1; m_loads++; end
      end
    end
  end
  task automatic cyc();
    @(posedge pix_clk); #1;
  endtask
  task automatic pulse_start();
    start = 1; cyc(); start = 0;
  endtask
  task automatic send(input logic [7:0] b);
    bool_wait: begin
      bus.in_byte = b; bus.in_valid = 1;
      for (int t = 0; t < 60; t++) begin
        @(negedge pix_clk);
        if (bus.in_ready) begin
          cyc(); bus.in_valid = 0;
          disable bool_wait;
        end
        cyc();
        if (rnd_bright) bright = $urandom_range(0, 2) == 0;
      end
      check("send_timeout", 0, 1);
      bus.in_valid = 0;
    end
  endtask
  task automatic wait_done();
    for (int t = 0; t < 300; t++) begin
      @(negedge pix_clk);
      if (done) begin cyc(); return; end
    end
    check("done_timeout", 0, 1);
  endtask
  initial begin
    int bad, d0, w0;
    bus.in_byte = 0; bus.in_valid = 0;
    #2 rst_n = 0;
    repeat (3) cyc();
    rst_n = 1;
    cyc();
    // key pixel then pure green, each written the cycle after its low byte
    pulse_start();
    send(8'hF8); send(8'h1F);
    @(negedge pix_clk); check("lat0_we", bus.mem_we, 1); check("lat0_data", bus.mem_wdata, 16'hF81F);
    check("lat0_addr", bus.mem_addr, 17'd5120);
    cyc();
    send(8'h07); send(8'hE0);
    @(negedge pix_clk); check("lat1_we", bus.mem_we, 1); check("lat1_data", bus.mem_wdata, 16'h07E0);
    check("lat1_addr", bus.mem_addr, 17'd5121);
    cyc();
    @(negedge pix_clk); check("pc_two", pixel_count, 2);
    cyc();
    // restart attempt while busy is ignored
    pulse_start();
    @(negedge pix_clk); check("pc_after_restart", pixel_count, 2);
    cyc();
    for (int i = 4; i < 2 * PIXELS; i++) send(8'($urandom));
    cyc();
    start = 1; cyc(); start = 0;
    @(negedge pix_clk); check("start_in_done_busy", busy, 0); check("full_pc", pixel_count, PIXELS);
    check("full_dones", dut_dones, 1); check("full_writes", m_writes, PIXELS);
    cyc();
    // byte offered in IDLE is held, not consumed
    bus.in_byte = 8'hA5; bus.in_valid = 1;
    bad = 0;
    repeat (10) begin @(negedge pix_clk); if (bus.in_ready) bad++; cyc(); end
    check("idle_no_consume", bad, 0); check("idle_pc", pixel_count, PIXELS);
    // that held byte becomes the high byte of the next load; bright stalls the word in WR
    pulse_start();
    bright = 1;
    @(negedge pix_clk);
    while (!bus.in_ready) begin cyc(); @(negedge pix_clk); end
    cyc(); bus.in_valid = 0;
    send(8'h5A);
    bad = 0;
    repeat (100) begin @(negedge pix_clk); if (bus.mem_we || bus.in_ready) bad++; end
    check("bright_hold", bad, 0);
    cyc(); bright = 0;
    @(negedge pix_clk); check("bright_release_we", bus.mem_we, 1); check("bright_word", bus.mem_wdata, 16'hA55A);
    check("bright_addr", bus.mem_addr, 17'd5120);
    cyc();
    @(negedge pix_clk); check("bright_once", bus.mem_we, 0);
    cyc();
    // reset after only a high byte drops the partial word
    send(8'h33);
    rst_n = 0;
    @(negedge pix_clk); check("midrst_we", bus.mem_we, 0); check("midrst_busy", busy, 0);
    check("midrst_addr", bus.mem_addr, BASE);
    cyc(); rst_n = 1; cyc();
    // random gaps and random bright over a whole image
    d0 = dut_dones; w0 = m_writes;
    rnd_bright = 1;
    pulse_start();
    for (int i = 0; i < 2 * PIXELS; i++) begin
      repeat ($urandom_range(0, 3)) begin cyc(); bright = $urandom_range(0, 2) == 0; end
      send(8'($urandom));
    end
    rnd_bright = 0; bright = 0;
    wait_done();
    repeat (5) cyc();
    check("rand_writes", m_writes - w0, PIXELS);
    check("rand_dones", dut_dones - d0, 1);
    check("rand_pc", pixel_count, PIXELS);
    check("loads", m_loads, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
